// File: rtl/eve_pkg.sv
// Shared types and PRNG field layout for the evolutionary mutation unit.
package eve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } eve_state_e;

  localparam int RND_W        = 36;
  localparam int RND_PROB_LSB = 0;
  localparam int RND_POS_LSB  = 8;
  localparam int RND_REPL_LSB = 20;

endpackage

// File: rtl/eve_mut_datapath.sv
// Combinational mutate decision and gene transform (bit flip or full replace).
module eve_mut_datapath
  import eve_pkg::*;
#(
  parameter int GENE_W = 16
) (
  input  logic [GENE_W-1:0] gene_in,
  input  logic [RND_W-1:0]  rnd_in,
  input  logic [7:0]        mut_prob,
  input  logic              mut_mode,
  output logic [GENE_W-1:0] gene_xf,
  output logic              mutate
);

  localparam int POS_W = $clog2(GENE_W);

  logic [7:0]        prob_rnd_s;
  logic [POS_W-1:0]  pos_s;
  logic [GENE_W-1:0] flip_s;
  logic [GENE_W-1:0] repl_s;
  logic              rnd_unused_s;

  assign prob_rnd_s   = rnd_in[RND_PROB_LSB +: 8];
  assign pos_s        = rnd_in[RND_POS_LSB +: POS_W];
  assign repl_s       = rnd_in[RND_REPL_LSB +: GENE_W];
  assign flip_s       = gene_in ^ (GENE_W'(1) << pos_s);
  // Field widths depend on GENE_W, so some PRNG bits are legitimately dropped.
  assign rnd_unused_s = ^rnd_in;

  // Select the transformed gene when the PRNG byte falls below the threshold.
  always_comb begin
    mutate  = 1'b0;
    gene_xf = gene_in;
    if (prob_rnd_s < mut_prob) begin
      mutate = 1'b1;
      if (mut_mode) begin
        gene_xf = repl_s;
      end else begin
        gene_xf = flip_s;
      end
    end else begin
      mutate  = 1'b0;
      gene_xf = gene_in;
    end
  end

endmodule

// File: rtl/eve_mutation_unit.sv
// Mutation unit: genome FSM, registered gene stream, optional mutation counter.
// The counter exists only when EVE_MUT_COUNT_EN is defined; otherwise mut_count is 0.
module eve_mutation_unit
  import eve_pkg::*;
#(
  parameter int GENE_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RND_W-1:0]  rnd_in,
  input  logic              start,
  input  logic [7:0]        mut_prob,
  input  logic              mut_mode,
  input  logic [GENE_W-1:0] gene_in,
  input  logic              gene_in_valid,
  input  logic              gene_in_last,
  output logic              gene_in_ready,
  output logic [GENE_W-1:0] gene_out,
  output logic              gene_out_valid,
  output logic              gene_out_last,
  input  logic              gene_out_ready,
  output logic              gene_out_mut,
  output logic              done,
  output logic [CNT_W-1:0]  mut_count
);

  eve_state_e        state_r;
  logic [7:0]        mut_prob_r;
  logic              mut_mode_r;
  logic              last_seen_r;
  logic [GENE_W-1:0] gene_out_r;
  logic              gene_out_valid_r;
  logic              gene_out_last_r;
  logic              gene_out_mut_r;
  logic              done_r;

  logic              gene_in_ready_s;
  logic              accept_s;
  logic              drain_s;
  logic              start_ok_s;
  logic [GENE_W-1:0] gene_xf_s;
  logic              mutate_s;

  eve_mut_datapath #(.GENE_W(GENE_W)) u_datapath (
    .gene_in  (gene_in),
    .rnd_in   (rnd_in),
    .mut_prob (mut_prob_r),
    .mut_mode (mut_mode_r),
    .gene_xf  (gene_xf_s),
    .mutate   (mutate_s)
  );

  assign gene_in_ready_s = (state_r == RUN) && (!gene_out_valid_r || gene_out_ready) && !last_seen_r;
  assign accept_s        = gene_in_valid && gene_in_ready_s;
  assign drain_s         = gene_out_valid_r && gene_out_ready;
  assign start_ok_s      = (state_r == IDLE) && start;

  assign gene_in_ready  = gene_in_ready_s;
  assign gene_out       = gene_out_r;
  assign gene_out_valid = gene_out_valid_r;
  assign gene_out_last  = gene_out_last_r;
  assign gene_out_mut   = gene_out_mut_r;
  assign done           = done_r;

  // Genome FSM, config latch and the single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r          <= IDLE;
      mut_prob_r       <= 8'd0;
      mut_mode_r       <= 1'b0;
      last_seen_r      <= 1'b0;
      gene_out_r       <= {GENE_W{1'b0}};
      gene_out_valid_r <= 1'b0;
      gene_out_last_r  <= 1'b0;
      gene_out_mut_r   <= 1'b0;
      done_r           <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= RUN;
            mut_prob_r  <= mut_prob;
            mut_mode_r  <= mut_mode;
            last_seen_r <= 1'b0;
          end
        end
        RUN: begin
          // An accept can overwrite a slot draining in the same cycle.
          if (accept_s) begin
            gene_out_r       <= gene_xf_s;
            gene_out_valid_r <= 1'b1;
            gene_out_last_r  <= gene_in_last;
            gene_out_mut_r   <= mutate_s;
            if (gene_in_last) begin
              last_seen_r <= 1'b1;
            end
          end else if (drain_s) begin
            gene_out_valid_r <= 1'b0;
            if (gene_out_last_r) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r     <= IDLE;
          last_seen_r <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef EVE_MUT_COUNT_EN
  logic [CNT_W-1:0] mut_count_r;

  // Saturating count of mutated genes accepted in the current genome.
  always_ff @(posedge clk) begin
    if (reset) begin
      mut_count_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      mut_count_r <= {CNT_W{1'b0}};
    end else if (accept_s && mutate_s && (mut_count_r != {CNT_W{1'b1}})) begin
      mut_count_r <= mut_count_r + CNT_W'(1);
    end
  end

  assign mut_count = mut_count_r;
`else
  logic start_unused_s;
  assign start_unused_s = start_ok_s;
  assign mut_count      = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_eve_mutation_unit.sv
// Self-checking bench: directed genomes plus randomized traffic against a behavioural model.
module tb_eve_mutation_unit;

  localparam int GENE_W = 16;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [35:0]       rnd_in;
  logic              start;
  logic [7:0]        mut_prob;
  logic              mut_mode;
  logic [GENE_W-1:0] gene_in;
  logic              gene_in_valid;
  logic              gene_in_last;
  logic              gene_in_ready;
  logic [GENE_W-1:0] gene_out;
  logic              gene_out_valid;
  logic              gene_out_last;
  logic              gene_out_ready;
  logic              gene_out_mut;
  logic              done;
  logic [CNT_W-1:0]  mut_count;

  int checks   = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  eve_mutation_unit #(.GENE_W(GENE_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .rnd_in         (rnd_in),
    .start          (start),
    .mut_prob       (mut_prob),
    .mut_mode       (mut_mode),
    .gene_in        (gene_in),
    .gene_in_valid  (gene_in_valid),
    .gene_in_last   (gene_in_last),
    .gene_in_ready  (gene_in_ready),
    .gene_out       (gene_out),
    .gene_out_valid (gene_out_valid),
    .gene_out_last  (gene_out_last),
    .gene_out_ready (gene_out_ready),
    .gene_out_mut   (gene_out_mut),
    .done           (done),
    .mut_count      (mut_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {last, mutated, gene} for one accepted gene, straight from the mutation rules.
  function automatic logic [17:0] model(input logic [15:0] g, input logic last,
                                        input logic [35:0] r, input logic [7:0] p, input logic m);
    int unsigned byte_v;
    int unsigned pos;
    logic [15:0] o;
    logic        mu;
    byte_v = r % 256;
    pos    = (r / 256) % 16;
    mu     = (byte_v < p);
    if (!mu)    o = g;
    else if (m) o = 16'(r / (36'd1 << 20));
    else        o = g ^ 16'(1 << pos);
    return {last, mu, o};
  endfunction

  // gkind: 0 random, 1 sequence 1..n, 2 zero. rkind: 0 random, 1 fixed, 2 random with byte 0.
  // skind: 0 always ready, 1 random ready, 2 stall 5 cycles whenever output pending.
  task automatic run_genome(input int n, input logic [7:0] p, input logic m, input int gkind,
                            input int rkind, input logic [35:0] rfix, input int skind);
    int sent, recv, cyc, stall_left, mcnt, exp_cnt;
    logic        held_v;
    logic [17:0] held, e;
    logic [35:0] r;
    exp_q.delete();
    @(negedge clk);
    start = 1'b1; mut_prob = p; mut_mode = m;
    @(negedge clk);
    start = 1'b0; mut_prob = 8'($urandom); mut_mode = 1'($urandom);
    check("ready_after_start", 64'(gene_in_ready), 64'd1);
    sent = 0; recv = 0; cyc = 0; mcnt = 0; held_v = 1'b0; held = 18'd0;
    stall_left = (skind == 2) ? 5 : 0;
    while (recv < n && cyc < 2000) begin
      if (skind == 0) gene_out_ready = 1'b1;
      else if (skind == 1) gene_out_ready = 1'($urandom);
      else begin
        gene_out_ready = !(gene_out_valid && stall_left > 0);
        if (gene_out_valid && stall_left > 0) stall_left--;
        else if (!gene_out_valid) stall_left = 5;
      end
      start = ($urandom % 6 == 0); mut_prob = 8'($urandom); mut_mode = 1'($urandom);
      if (held_v) begin
        check("hold_valid", 64'(gene_out_valid), 64'd1);
        check("hold_data", 64'({gene_out_last, gene_out_mut, gene_out}), 64'(held));
      end
      held_v = 1'b0;
      if (gene_out_valid) begin
        if (gene_out_ready) begin
          if (exp_q.size() == 0) check("spurious_out", 64'(gene_out_valid), 64'd0);
          else begin
            e = exp_q.pop_front();
            check("gene_out", 64'({gene_out_last, gene_out_mut, gene_out}), 64'(e));
            recv++;
          end
        end else begin
          held_v = 1'b1;
          held   = {gene_out_last, gene_out_mut, gene_out};
        end
      end
      if (sent < n && (gkind != 0 || $urandom % 4 != 0)) begin
        gene_in_valid = 1'b1;
        gene_in = (gkind == 1) ? 16'(sent + 1) : (gkind == 2) ? 16'd0 : 16'($urandom);
        gene_in_last = (sent == n - 1);
      end else begin
        gene_in_valid = 1'b0;
        gene_in = 16'($urandom);
        gene_in_last = 1'($urandom);
      end
      r = 36'({$urandom, $urandom});
      if (rkind == 1) r = rfix;
      else if (rkind == 2) r = r & ~36'hFF;
      rnd_in = r;
      #1;
      if (gene_out_valid && !gene_out_ready) check("stall_in_ready", 64'(gene_in_ready), 64'd0);
      if (gene_in_valid && gene_in_ready) begin
        e = model(gene_in, gene_in_last, r, p, m);
        exp_q.push_back(e);
        if (e[16]) mcnt++;
        sent++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; gene_in_valid = 1'b0;
    check("genome_complete", 64'(recv), 64'(n));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef EVE_MUT_COUNT_EN
    exp_cnt = (mcnt > 3) ? 3 : mcnt;
`else
    exp_cnt = 0;
`endif
    check("done_pulse", 64'(done), 64'd1);
    check("mut_count", 64'(mut_count), 64'(exp_cnt));
    @(negedge clk);
    check("done_low", 64'(done), 64'd0);
    check("idle_in_ready", 64'(gene_in_ready), 64'd0);
  endtask

  initial begin
    reset = 1'b1; rnd_in = 36'd0; start = 1'b0; mut_prob = 8'd0; mut_mode = 1'b0;
    gene_in = 16'd0; gene_in_valid = 1'b0; gene_in_last = 1'b0; gene_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 64'({gene_out_valid, gene_out_last, gene_out_mut, done, gene_in_ready}), 64'd0);
    check("rst_gene_out", 64'(gene_out), 64'd0);
    check("rst_mut_count", 64'(mut_count), 64'd0);
    reset = 1'b0;

    run_genome(8, 8'd0, 1'b0, 1, 0, 36'd0, 0);
    run_genome(4, 8'd255, 1'b0, 2, 1, 36'h000000300, 0);
    run_genome(5, 8'd255, 1'b1, 0, 1, 36'hABCD00000, 1);
    run_genome(6, 8'd128, 1'b0, 0, 0, 36'd0, 2);
    run_genome(6, 8'd255, 1'b0, 0, 2, 36'd0, 0);
    for (int k = 0; k < 6; k++)
      run_genome(1 + int'($urandom % 12), 8'($urandom), 1'($urandom), 0, 0, 36'd0, 1);

    // Reset mid-genome with an output pending.
    @(negedge clk);
    start = 1'b1; mut_prob = 8'd255; mut_mode = 1'b0;
    @(negedge clk);
    start = 1'b0; gene_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gene_in_valid = 1'b1; gene_in = 16'(i + 5); gene_in_last = 1'b0;
      rnd_in = 36'({$urandom, $urandom});
      @(negedge clk);
    end
    gene_in_valid = 1'b0; gene_out_ready = 1'b0;
    check("pending_before_reset", 64'(gene_out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state", 64'({gene_out_valid, gene_out_last, gene_out_mut, done, gene_in_ready}), 64'd0);
    check("midrst_gene_out", 64'(gene_out), 64'd0);
    check("midrst_mut_count", 64'(mut_count), 64'd0);
    reset = 1'b0; gene_out_ready = 1'b1;
    @(negedge clk);
    check("no_delivery_after_rst", 64'(gene_out_valid), 64'd0);
    check("idle_after_rst", 64'(gene_in_ready), 64'd0);
    run_genome(3, 8'd200, 1'b1, 0, 0, 36'd0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eve_mutation_unit.md
EVE_MUTATION_UNIT -- requirements
Module: eve_mutation_unit

Interface
REQ-001 Parameter: GENE_W, default 16, gene width; power of two, 4..16.
REQ-002 Parameter: CNT_W, default 10, mutation-counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rnd_in  input  36  free-running PRNG word from the per-PE generator, new value every cycle.
REQ-006 start  input  1  one-cycle pulse; latches cfg and opens a genome.
REQ-007 mut_prob  input  8  mutation threshold, latched on accepted start.
REQ-008 mut_mode  input  1  0 = single-bit flip, 1 = random gene replace; latched on start.
REQ-009 gene_in / gene_in_valid / gene_in_last / gene_in_ready  in/in/in/out  GENE_W/1/1/1  upstream gene stream.
REQ-010 gene_out / gene_out_valid / gene_out_last / gene_out_ready  out/out/out/in  GENE_W/1/1/1  downstream gene stream.
REQ-011 gene_out_mut  output  1  marks that the current gene_out was mutated.
REQ-012 done  output  1  one-cycle pulse after the genome completes.
REQ-013 mut_count  output  CNT_W  number of mutations in the last genome; valid while done = 1.

Function
REQ-014 FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start.
- RUN -> DONE when a gene with gene_in_last = 1 is accepted and has left the output register.
- DONE -> IDLE after 1 cycle.
REQ-015 gene_in_ready = (state == RUN) && (!gene_out_valid || gene_out_ready) && !last_seen; it is 0 in IDLE and DONE.
REQ-016 A transfer occurs when valid && ready; the output is registered with latency 1, and rnd_in is sampled in the accept cycle.
REQ-017 Mutate decision: mutate = (rnd_in[7:0] < mut_prob_q); mut_prob = 0 never mutates, and 255 mutates unless rnd_in[7:0] = 255.
REQ-018 Flip mode: gene_out = gene_in ^ (1 << rnd_in[8 +: log2(GENE_W)]).
REQ-019 Replace mode: gene_out = rnd_in[20 +: GENE_W].
REQ-020 When not mutated, gene_out = gene_in and gene_out_mut = 0; gene_out_last is forwarded from gene_in_last.
REQ-021 gene_out_valid, once high, holds gene_out, gene_out_last and gene_out_mut stable until gene_out_ready.
REQ-022 mut_count increments on each accepted mutated gene and saturates at 2^CNT_W-1; it clears on start.
REQ-023 start is ignored outside IDLE.
REQ-024 If start and RUN->DONE coincide, start is ignored.
REQ-025 An empty genome (no genes before next start) is impossible by protocol; the block waits in RUN indefinitely.

Reset
REQ-026 Reset returns the FSM to IDLE from any state, including mid-genome with a pending output.
REQ-027 Reset values: gene_out_valid = 0, gene_out = 0, gene_out_last = 0, gene_out_mut = 0, done = 0, mut_count = 0, latched cfg = 0, last_seen = 0.
REQ-028 A pending output is discarded on reset, not delivered.

Configuration
REQ-029 Macro EVE_MUT_COUNT_EN: when defined, the mutation counter and saturation logic are implemented as in REQ-022.
REQ-030 When EVE_MUT_COUNT_EN is undefined, mut_count is tied to 0 and no counter flops are implemented; done behaviour is unchanged.

Structure
REQ-031 A shared package eve_pkg holds:
- the FSM state enum;
- RND_W = 36;
- field offsets RND_PROB_LSB = 0, RND_POS_LSB = 8, RND_REPL_LSB = 20.
REQ-032 One sub-module, eve_mut_datapath: combinational mutate decision and gene transform (REQ-017..020); FSM, handshake and counter stay in the top.

Verification
REQ-033 mut_prob = 0, flip mode, 8 genes 0x0001..0x0008 -> outputs identical, gene_out_mut = 0, done pulse, mut_count = 0.
REQ-034 mut_prob = 255, flip mode, rnd_in = 0x000000300, gene_in = 0x0000 -> gene_out = 0x0008, gene_out_mut = 1.
REQ-035 Replace mode, mut_prob = 255, rnd_in = 0xABCD00000 -> gene_out = 0xABCD for any gene_in.
REQ-036 gene_out_ready held low 5 cycles with valid output -> gene_in_ready = 0, gene_out stable, no gene lost or duplicated.
REQ-037 Reset asserted mid-genome after 3 genes -> next cycle all outputs at reset values, state IDLE, gene_in_ready = 0.
REQ-038 CNT_W = 2, 6 forced mutations -> mut_count = 3 with EVE_MUT_COUNT_EN defined, 0 with it undefined.
